key_led_ctrl: RTL

//  Parametrised key-to-LED controller for the lab top level. Per channel: synchronise, debounce
//  and press-detect the raw keys, then drive the LED bank in one of four modes: direct, toggle,

---
 rtl/key_led_pkg.sv | 15 +
 rtl/key_debounce.sv | 65 ++++++
 rtl/key_led_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/key_led_pkg.sv
// Shared types and constants for the key-to-LED controller.
package key_led_pkg;

    // LED display modes, encoded to match the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_DIRECT,
        MODE_TOGGLE,
        MODE_COUNT,
        MODE_DEMORGAN
    } mode_t;

    // Synchroniser depth for the asynchronous key inputs.
    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/key_debounce.sv
// One key channel: two-flop synchroniser, debounce counter, stable level and press pulse.
module key_debounce
    import key_led_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic stable_o,
    output logic press_next_o,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   stable_dly_q;
    logic                   press_q, press_d;

    assign synced = sync_q[SYNC_STAGES-1];

    // Accept a new level only after it has differed from stable for DEBOUNCE edges.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (synced == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d = synced;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pulse on the edge after stable rises; stable_dly_q remembers the previous stable level.
    assign press_d = stable_q & ~stable_dly_q;

    // Synchroniser, debounce state and press pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], key_i};
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= press_d;
        end
    end

    assign stable_o     = stable_q;
    assign press_next_o = press_d;
    assign press_o      = press_q;

endmodule

// File: rtl/key_led_ctrl.sv
// Key-to-LED controller: per-key debounce, toggle bits, press counter and mode-selected LED bank.
module key_led_ctrl
    import key_led_pkg::*;
#(
    parameter int unsigned w_key    = 4,
    parameter int unsigned w_led    = 8,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [w_key-1:0] key,
    input  logic [1:0]       mode,
    output logic [w_led-1:0] led,
    output logic [w_key-1:0] key_press
);

    logic [w_key-1:0] stable;
    logic [w_key-1:0] press_next;
    logic [w_key-1:0] toggle_q, toggle_d;
    logic [w_led-1:0] count_q, count_d;
    logic [w_led-1:0] led_q, led_d;
    mode_t            mode_s;

    assign mode_s = mode_t'(mode);

    for (genvar i = 0; i < w_key; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_key_debounce (
            .clk          (clk),
            .rst_n        (rst_n),
            .key_i        (key[i]),
            .stable_o     (stable[i]),
            .press_next_o (press_next[i]),
            .press_o      (key_press[i])
        );
    end

    // Toggle and count advance from the pulses being registered this edge, so the LEDs
    // update on the same edge as key_press.
    always_comb begin
        toggle_d = toggle_q ^ press_next;
        count_d  = count_q;
        for (int i = 0; i < w_key; i++) begin
            count_d = count_d + w_led'(press_next[i]);
        end
    end

    // Mode-selected LED pattern; stable is what the press-edge register will hold next.
    always_comb begin
        led_d = '0;
        unique case (mode_s)
            MODE_DIRECT: led_d[w_key-1:0] = stable;
            MODE_TOGGLE: led_d[w_key-1:0] = toggle_d;
            MODE_COUNT:  led_d            = count_d;
            MODE_DEMORGAN: begin
                led_d[0] = ~&stable;
                led_d[1] = |(~stable);
                led_d[2] = ~|stable;
                led_d[3] = &(~stable);
            end
            default: led_d = '0;
        endcase
    end

    // Toggle bits, press count and LED register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= '0;
            count_q  <= '0;
            led_q    <= '0;
        end else begin
            toggle_q <= toggle_d;
            count_q  <= count_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;

endmodule
